// File: rtl/tick_monitor.sv
// tick_monitor
//   Measures the interval between ticks on en_in, declares lock once
//   LOCK_CNT consecutive intervals equal N+1 cycles, and flags wrong
//   periods (while locked) and missing ticks (interval reaching TIMEOUT).
//
// Parameters
//   N        expected tick period is N+1 clk cycles
//   W        width of the interval counter and of period
//   LOCK_CNT consecutive correct periods needed to assert locked
//   TIMEOUT  interval length in cycles at which a missing tick is declared
//
// Ports
//   clk         clock, rising edge active
//   rst         asynchronous active-low reset (release synchronised to clk)
//   en_in       tick under test, sampled on rising clk
//   clr         synchronous clear of state and sticky flags (period kept)
//   period      last measured tick interval in cycles (saturating)
//   period_vld  one-cycle pulse marking period as updated
//   locked      high while the tick period equals N+1
//   err_period  sticky: wrong period observed while locked
//   err_timeout sticky: missing tick observed
module tick_monitor #(
  parameter int N        = 11,
  parameter int W        = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_in,
  input  logic         clr,
  output logic [W-1:0] period,
  output logic         period_vld,
  output logic         locked,
  output logic         err_period,
  output logic         err_timeout
);

  localparam int          MW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned NP1 = N + 1;
  localparam int unsigned TMO = TIMEOUT;
  localparam logic [MW-1:0] LC = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, LOST} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [MW-1:0] match_q, match_d;
  logic [W-1:0]  period_q, period_d;
  logic          vld_q, vld_d;
  logic          locked_q, locked_d;
  logic          err_period_q, err_period_d;
  logic          err_timeout_q, err_timeout_d;

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_ok;

  logic [W-1:0]  cnt_p1;
  logic [MW-1:0] match_inc;
  logic          rpt_ok;
  logic          timeout_hit;

  // Two-stage release synchroniser; the state flops are held at their
  // reset values until it has seen two clean edges with rst high.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_ok     = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    match_d       = match_q;
    period_d      = period_q;
    vld_d         = 1'b0;
    locked_d      = locked_q;
    err_period_d  = err_period_q;
    err_timeout_d = err_timeout_q;

    // cnt+1 saturating at 2^W-1 serves both as the next count and as the
    // reported interval on a tick.
    cnt_p1      = (cnt_q == '1) ? '1 : cnt_q + W'(1);
    match_inc   = (match_q == LC) ? LC : match_q + MW'(1);
    rpt_ok      = (32'(cnt_p1) == NP1);
    timeout_hit = ((32'(cnt_q) + 32'd1) >= TMO);

    case (state_q)
      IDLE: begin
        if (en_in) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      LOST: begin
        if (en_in) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end else begin
          cnt_d = cnt_p1;
        end
      end
      MEASURE, LOCKED: begin
        if (en_in) begin
          period_d = cnt_p1;
          vld_d    = 1'b1;
          cnt_d    = '0;
          match_d  = rpt_ok ? match_inc : '0;
          if (state_q == MEASURE) begin
            if (rpt_ok && (match_inc == LC)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (!rpt_ok) begin
            state_d      = MEASURE;
            locked_d     = 1'b0;
            err_period_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d       = LOST;
          locked_d      = 1'b0;
          err_timeout_d = 1'b1;
          match_d       = '0;
          cnt_d         = cnt_p1;
        end else begin
          cnt_d = cnt_p1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr) begin
      state_d       = IDLE;
      cnt_d         = '0;
      match_d       = '0;
      period_d      = period_q;
      vld_d         = 1'b0;
      locked_d      = 1'b0;
      err_period_d  = 1'b0;
      err_timeout_d = 1'b0;
    end

    if (!rst_ok) begin
      state_d       = IDLE;
      cnt_d         = '0;
      match_d       = '0;
      period_d      = '0;
      vld_d         = 1'b0;
      locked_d      = 1'b0;
      err_period_d  = 1'b0;
      err_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      match_q       <= '0;
      period_q      <= '0;
      vld_q         <= 1'b0;
      locked_q      <= 1'b0;
      err_period_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      match_q       <= match_d;
      period_q      <= period_d;
      vld_q         <= vld_d;
      locked_q      <= locked_d;
      err_period_q  <= err_period_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign period      = period_q;
  assign period_vld  = vld_q;
  assign locked      = locked_q;
  assign err_period  = err_period_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_tick_monitor.sv
// tb_tick_monitor
//   Drives two tick_monitor instances (default W=8/TIMEOUT=24 and
//   W=4/TIMEOUT=40) with shared directed and randomized tick streams and
//   compares every output each cycle against a time-stamp based model.
module tb_tick_monitor;

  localparam int N  = 11;
  localparam int LK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_in = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] period1;
  logic       vld1, locked1, ep1, et1;
  logic [3:0] period2;
  logic       vld2, locked2, ep2, et2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  always #5 clk = ~clk;

  tick_monitor #(.N(N), .W(8), .LOCK_CNT(LK), .TIMEOUT(24)) dut1 (
    .clk(clk), .rst(rst), .en_in(en_in), .clr(clr),
    .period(period1), .period_vld(vld1), .locked(locked1),
    .err_period(ep1), .err_timeout(et1)
  );

  tick_monitor #(.N(N), .W(4), .LOCK_CNT(LK), .TIMEOUT(40)) dut2 (
    .clk(clk), .rst(rst), .en_in(en_in), .clr(clr),
    .period(period2), .period_vld(vld2), .locked(locked2),
    .err_period(ep2), .err_timeout(et2)
  );

  // Model: remembers the cycle of the reference tick and derives the
  // interval by subtraction; locked means the run of correct periods
  // has reached LK.
  typedef struct {
    bit have;
    bit lost;
    int last;
    int run;
    bit vld;
    int period;
    bit ep;
    bit et;
  } mdl_t;

  mdl_t m1, m2;

  function automatic void mreset(inout mdl_t m);
    m.have = 0; m.lost = 0; m.last = 0; m.run = 0;
    m.vld = 0; m.period = 0; m.ep = 0; m.et = 0;
  endfunction

  function automatic void mstep(inout mdl_t m, input bit c, input bit e,
                                input int cyc, input int w, input int tmo);
    int iv;
    int p;
    int maxv;
    maxv  = (1 << w) - 1;
    m.vld = 0;
    if (c) begin
      m.have = 0; m.lost = 0; m.run = 0; m.ep = 0; m.et = 0;
      return;
    end
    if (!m.have) begin
      if (e) begin m.have = 1; m.last = cyc; end
      return;
    end
    if (m.lost) begin
      if (e) begin m.lost = 0; m.last = cyc; end
      return;
    end
    iv = cyc - m.last;
    if (e) begin
      p = (iv > maxv) ? maxv : iv;
      m.period = p;
      m.vld    = 1;
      m.last   = cyc;
      if (p == N + 1) begin
        if (m.run < LK) m.run++;
      end else begin
        if (m.run == LK) m.ep = 1;
        m.run = 0;
      end
    end else if (iv == tmo && tmo <= maxv + 1) begin
      m.lost = 1;
      m.run  = 0;
      m.et   = 1;
    end
  endfunction

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc_n, act, exp);
    end
  endtask

  task automatic compare_all();
    check("d1_period", int'(period1), m1.period);
    check("d1_vld",    int'(vld1),    int'(m1.vld));
    check("d1_locked", int'(locked1), int'(m1.run == LK));
    check("d1_errp",   int'(ep1),     int'(m1.ep));
    check("d1_errt",   int'(et1),     int'(m1.et));
    check("d2_period", int'(period2), m2.period);
    check("d2_vld",    int'(vld2),    int'(m2.vld));
    check("d2_locked", int'(locked2), int'(m2.run == LK));
    check("d2_errp",   int'(ep2),     int'(m2.ep));
    check("d2_errt",   int'(et2),     int'(m2.et));
  endtask

  task automatic step(input bit c, input bit e);
    clr   = c;
    en_in = e;
    @(posedge clk);
    #1;
    cyc_n++;
    mstep(m1, c, e, cyc_n, 8, 24);
    mstep(m2, c, e, cyc_n, 4, 40);
    compare_all();
  endtask

  task automatic ticks(input int iv, input int count);
    for (int k = 0; k < count; k++) begin
      for (int j = 0; j < iv - 1; j++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_p1"}, int'(period1), 0);
    check({tag, "_v1"}, int'(vld1),    0);
    check({tag, "_l1"}, int'(locked1), 0);
    check({tag, "_e1"}, int'(ep1) + int'(et1), 0);
    check({tag, "_p2"}, int'(period2), 0);
    check({tag, "_l2"}, int'(locked2) + int'(vld2) + int'(ep2) + int'(et2), 0);
  endtask

  task automatic release_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int iv;
    mreset(m1);
    mreset(m2);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_zero("rst");
    release_reset();
    check_reset_zero("post_rst");

    // steady 12-cycle ticks: lock on the 4th reported period
    ticks(12, 4);
    check("s1_not_yet_locked", int'(locked1), 0);
    ticks(12, 1);
    check("s1_locked", int'(locked1), 1);
    check("s1_period", int'(period1), 12);
    ticks(12, 2);
    check("s1_no_err", int'(ep1) + int'(et1), 0);

    // one short interval while locked, then relock
    ticks(10, 1);
    check("s2_period", int'(period1), 10);
    check("s2_unlock", int'(locked1), 0);
    check("s2_errp",   int'(ep1), 1);
    ticks(12, 4);
    check("s2_relock", int'(locked1), 1);
    check("s2_errp_sticky", int'(ep1), 1);

    // ticks stop: timeout, then a fresh first tick
    for (int j = 0; j < 30; j++) step(1'b0, 1'b0);
    check("s3_errt",   int'(et1), 1);
    check("s3_unlock", int'(locked1), 0);
    step(1'b0, 1'b1);
    check("s3_no_vld", int'(vld1), 0);
    ticks(12, 1);
    check("s3_period", int'(period1), 12);
    check("s3_vld",    int'(vld1), 1);

    // reset mid-measurement discards the partial interval
    for (int j = 0; j < 5; j++) step(1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_reset_zero("mid_rst");
    mreset(m1);
    mreset(m2);
    @(posedge clk);
    #1;
    release_reset();

    // en_in high for three cycles
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("s4_period_a", int'(period1), 1);
    step(1'b0, 1'b1);
    check("s4_period_b", int'(period1), 1);
    check("s4_vld", int'(vld1), 1);
    check("s4_match", int'(dut1.match_q), 0);

    // lock, then clr together with a tick
    ticks(12, 5);
    check("s5_locked", int'(locked1), 1);
    for (int j = 0; j < 11; j++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("s5_clr_period", int'(period1), 12);
    check("s5_clr_vld",    int'(vld1), 0);
    check("s5_clr_flags",  int'(locked1) + int'(ep1) + int'(et1), 0);

    // 20-cycle interval on the W=4 instance saturates to 15
    step(1'b0, 1'b1);
    ticks(20, 1);
    check("s6_sat", int'(period2), 15);
    check("s6_wide", int'(period1), 20);

    // randomized intervals with occasional clr
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0: iv = 1;
        1: iv = 10;
        2: iv = 11;
        3: iv = 13;
        4: iv = $urandom_range(20, 30);
        5: iv = $urandom_range(38, 46);
        default: iv = 12;
      endcase
      for (int j = 0; j < iv - 1; j++) step(1'b0, 1'b0);
      step(($urandom_range(0, 24) == 0), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
